state_dump_unit: RTL and testbench

Reads architectural state out of the pipelined CPU: all general registers, then the first data-memory bytes, streamed as 32-bit beats over a valid/ready interface.
It is the read-side counterpart of the memory/register preload path, used by bring-up logic and benches to take a coherent snapshot.
It sits beside the CPU top and uses a dedicated RF read port and DM byte read port.
It holds the pipeline frozen while dumping.

---
 rtl/dump_pkg.sv | 23 ++
 rtl/state_dump_unit.sv | 134 +++++++++++++
 tb/tb_state_dump_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dump_pkg.sv
// Shared types and defaults for the architectural state dump unit.
package dump_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRfRd,
        StRfOut,
        StDmRd,
        StDmOut,
        StDone
    } dump_state_e;

    localparam logic TAG_RF = 1'b0;
    localparam logic TAG_DM = 1'b1;

    localparam int unsigned DefNumRegs = 32;
    localparam int unsigned DefDmBytes = 32;
    localparam int unsigned DefDataW   = 32;

    // Beat index width; bits 6:0 of the tag carry it.
    localparam int unsigned IdxW = 7;

endpackage

// File: rtl/state_dump_unit.sv
// Streams every general register, then the low data-memory bytes, as tagged valid/ready beats
// while holding the CPU frozen.
module state_dump_unit
    import dump_pkg::*;
#(
    parameter int unsigned NUM_REGS = DefNumRegs,
    parameter int unsigned DM_BYTES = DefDmBytes,
    parameter int unsigned DATA_W   = DefDataW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic [4:0]        rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [6:0]        dm_addr_o,
    input  logic [7:0]        dm_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [7:0]        dump_tag_o,
    output logic              dump_last_o,
    output logic              done_o
);

    localparam logic [IdxW-1:0] RfLastIdx = IdxW'(NUM_REGS - 1);
    localparam logic [IdxW-1:0] DmLastIdx = IdxW'(DM_BYTES - 1);

    dump_state_e       state_q;
    logic [IdxW-1:0]   idx_q;
    logic [IdxW-1:0]   idx_inc;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;
    logic              last_q;
    logic [DATA_W-1:0] data_q;
    logic [7:0]        tag_q;
    logic [4:0]        rf_addr_q;
    logic [6:0]        dm_addr_q;

    assign idx_inc = idx_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
            tag_q     <= '0;
            rf_addr_q <= '0;
            dm_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q   <= StRfRd;
                        idx_q     <= '0;
                        rf_addr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                StRfRd: begin
                    data_q  <= rf_data_i;
                    tag_q   <= {TAG_RF, idx_q};
                    last_q  <= 1'b0;
                    valid_q <= 1'b1;
                    state_q <= StRfOut;
                end
                StRfOut: begin
                    if (dump_ready_i) begin
                        valid_q <= 1'b0;
                        if (idx_q == RfLastIdx) begin
                            idx_q     <= '0;
                            dm_addr_q <= '0;
                            state_q   <= StDmRd;
                        end else begin
                            idx_q     <= idx_inc;
                            rf_addr_q <= idx_inc[4:0];
                            state_q   <= StRfRd;
                        end
                    end
                end
                StDmRd: begin
                    data_q  <= {{(DATA_W - 8){1'b0}}, dm_data_i};
                    tag_q   <= {TAG_DM, idx_q};
                    last_q  <= (idx_q == DmLastIdx);
                    valid_q <= 1'b1;
                    state_q <= StDmOut;
                end
                StDmOut: begin
                    if (dump_ready_i) begin
                        valid_q <= 1'b0;
                        // last only accompanies valid, so it falls with the final handshake
                        last_q  <= 1'b0;
                        if (idx_q == DmLastIdx) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q     <= idx_inc;
                            dm_addr_q <= idx_inc;
                            state_q   <= StDmRd;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign cpu_hold_o   = busy_q;
    assign rf_addr_o    = rf_addr_q;
    assign dm_addr_o    = dm_addr_q;
    assign dump_valid_o = valid_q;
    assign dump_data_o  = data_q;
    assign dump_tag_o   = tag_q;
    assign dump_last_o  = last_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_state_dump_unit.sv
// Directed/randomised bench for state_dump_unit with an array-based model of the expected beat stream.
module tb_state_dump_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        cpu_hold_o;
    logic        busy_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_i;
    logic [6:0]  dm_addr_o;
    logic [7:0]  dm_data_i;
    logic        dump_valid_o;
    logic        dump_ready_i = 1'b0;
    logic [31:0] dump_data_o;
    logic [7:0]  dump_tag_o;
    logic        dump_last_o;
    logic        done_o;

    logic [31:0] rf_mem [32];
    logic [7:0]  dm_mem [128];

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    assign rf_data_i = rf_mem[rf_addr_o];
    assign dm_data_i = dm_mem[dm_addr_o];

    state_dump_unit dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .cpu_hold_o  (cpu_hold_o),
        .busy_o      (busy_o),
        .rf_addr_o   (rf_addr_o),
        .rf_data_i   (rf_data_i),
        .dm_addr_o   (dm_addr_o),
        .dm_data_i   (dm_data_i),
        .dump_valid_o(dump_valid_o),
        .dump_ready_i(dump_ready_i),
        .dump_data_o (dump_data_o),
        .dump_tag_o  (dump_tag_o),
        .dump_last_o (dump_last_o),
        .done_o      (done_o)
    );

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_ctl"}, 64'({busy_o, cpu_hold_o, dump_valid_o, dump_last_o, done_o,
                                 dump_tag_o, rf_addr_o, dm_addr_o}), 64'd0);
        check({nm, "_data"}, 64'(dump_data_o), 64'd0);
    endtask

    // Expected beat k from the memory images: registers first, then bytes.
    function automatic logic [40:0] exp_beat(input int k);
        logic [7:0]  tag;
        logic [31:0] data;
        logic        last;
        if (k < 32) begin
            tag  = 8'(k);
            data = rf_mem[k];
            last = 1'b0;
        end else begin
            tag  = 8'h80 + 8'(k - 32);
            data = {24'd0, dm_mem[k - 32]};
            last = (k == 63);
        end
        return {last, tag, data};
    endfunction

    task automatic run_dump(input bit rand_rdy, input int stall_tag, input int start_beat,
                            input int rst_tag);
        int          k = 0;
        int          cyc;
        int          stall = 0;
        int          done_seen = 0;
        bit          hs_last = 0;
        bit          sent = 0;
        bit          first_seen = 0;
        bit          stalled = 0;
        logic [31:0] pdata = '0;
        logic [7:0]  ptag = '0;
        logic [40:0] e;

        start_i = 1'b1;
        step();
        cyc = 1;
        start_i = 1'b0;
        check("busy_after_start", 64'(busy_o), 64'd1);
        check("hold_after_start", 64'(cpu_hold_o), 64'd1);
        check("valid_early", 64'(dump_valid_o), 64'd0);

        while (cyc < 2000) begin
            start_i = 1'b0;
            if (hs_last) begin
                check("done_pulse", 64'(done_o), 64'd1);
                check("busy_in_done", 64'(busy_o), 64'd1);
                if (!rand_rdy) check("done_cycle", 64'(cyc), 64'd129);
                done_seen++;
                step();
                check("done_drop", 64'(done_o), 64'd0);
                check("idle_flags", 64'({busy_o, cpu_hold_o, dump_valid_o, dump_last_o}), 64'd0);
                break;
            end
            if (done_o) done_seen++;
            if (stalled) begin
                check("hold_valid", 64'(dump_valid_o), 64'd1);
                check("hold_data", 64'(dump_data_o), 64'(pdata));
                check("hold_tag", 64'(dump_tag_o), 64'(ptag));
            end
            if (dump_valid_o && !first_seen) begin
                first_seen = 1;
                check("first_valid_cycle", 64'(cyc), 64'd2);
            end

            if (dump_valid_o && stall_tag >= 0 && dump_tag_o == 8'(stall_tag) && stall < 5) begin
                dump_ready_i = 1'b0;
                stall++;
            end else if (rand_rdy) begin
                dump_ready_i = ($urandom_range(0, 3) != 0);
            end else begin
                dump_ready_i = 1'b1;
            end

            if (rst_tag >= 0 && dump_valid_o && dump_tag_o == 8'(rst_tag)) begin
                rst_i = 1'b0;
                step();
                rst_i = 1'b1;
                check_reset_outputs("mid_reset");
                for (int i = 0; i < 4; i++) begin
                    step();
                    check("abort_no_done", 64'({done_o, busy_o, dump_valid_o}), 64'd0);
                end
                return;
            end

            if (start_beat >= 0 && k == start_beat && !sent) begin
                start_i = 1'b1;
                sent = 1;
            end

            if (dump_valid_o && dump_ready_i) begin
                e = exp_beat(k);
                check("beat_tag", 64'(dump_tag_o), 64'(e[39:32]));
                check("beat_data", 64'(dump_data_o), 64'(e[31:0]));
                check("beat_last", 64'(dump_last_o), 64'(e[40]));
                k++;
                if (k == 64) hs_last = 1;
            end else if (dump_valid_o) begin
                check("last_only_final", 64'(dump_last_o), 64'(exp_beat(k) >> 40));
            end else begin
                check("last_without_valid", 64'(dump_last_o), 64'd0);
            end

            stalled = dump_valid_o && !dump_ready_i;
            pdata   = dump_data_o;
            ptag    = dump_tag_o;
            step();
            cyc++;
        end
        start_i = 1'b0;
        check("beat_count", 64'(k), 64'd64);
        check("done_count", 64'(done_seen), 64'd1);
        if (stall_tag >= 0) check("stall_cycles", 64'(stall), 64'd5);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i * 3);
        for (int j = 0; j < 128; j++) dm_mem[j] = 8'(j + 1);

        rst_i = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        rst_i = 1'b1;
        step();
        check_reset_outputs("post_reset_idle");

        // Known pattern, ready always high.
        run_dump(1'b0, -1, -1, -1);
        step();

        // Random contents, random ready, 5-cycle stall on reg 5, spurious start at beat 10.
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        for (int j = 0; j < 32; j++) dm_mem[j] = 8'($urandom_range(0, 255));
        rf_mem[5] = 32'd15;
        run_dump(1'b1, 5, 10, -1);
        step();

        // Reset aborts during the beat for memory byte 3.
        for (int j = 0; j < 32; j++) dm_mem[j] = 8'($urandom_range(0, 255));
        run_dump(1'b1, -1, -1, 8'h83);
        step();

        // Restart from scratch; top byte 0xFF must arrive zero-extended with last.
        dm_mem[31] = 8'hFF;
        run_dump(1'b0, -1, -1, -1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
